// File: rtl/cnn_accel_pkg.sv
// Shared types for the CNN accelerator feature-map path: frame arbiter state encoding.
// FRAME_ARB_WATCHDOG_EN adds the PAD state used by the stall watchdog.
package cnn_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
`ifdef FRAME_ARB_WATCHDOG_EN
    ,
    ST_PAD    = 2'd3
`endif
  } arb_state_e;

`ifdef FRAME_ARB_WATCHDOG_EN
  localparam int ARB_NUM_STATES = 4;
`else
  localparam int ARB_NUM_STATES = 3;
`endif

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo NUM_CH.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     last_grant,
  output logic [CW-1:0]     idx,
  output logic              any
);

  logic [CW-1:0] cand;

  // Walk from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CW'((int'(last_grant) + k) % NUM_CH);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/fmap_frame_arbiter.sv
// Frame-granular round-robin arbiter merging NUM_CH feature-map producers into one pixel stream.
// Define FRAME_ARB_WATCHDOG_EN to zero-pad stalled frames after STALL_MAX idle cycles.
module fmap_frame_arbiter
  import cnn_accel_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WI        = 8,
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 128,
  parameter int STALL_MAX = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FRAME_SIZE = WIDTH * HEIGHT,
  localparam int CNT_W      = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_vld,
  input  logic [NUM_CH*WI-1:0] req_data,
  output logic [NUM_CH-1:0]    req_rdy,
  output logic [WI-1:0]        out_data,
  output logic                 out_vld,
  output logic [CH_W-1:0]      out_ch,
  output logic                 frame_done,
`ifdef FRAME_ARB_WATCHDOG_EN
  output logic                 frame_err,
`endif
  output logic                 busy
);

  if (NUM_CH < 2 || NUM_CH > 8 || STALL_MAX < 1 || ARB_NUM_STATES < 3) begin : g_param_check
    $error("fmap_frame_arbiter: unsupported parameter set");
  end

  arb_state_e        state, state_nxt;
  logic [CH_W-1:0]   grant, last_grant, pick_idx;
  logic              pick_any;
  logic [CNT_W-1:0]  pix_cnt;
  logic              xfer, last_pix, pad_emit;
  logic [WI-1:0]     gnt_pix;
  logic [WI-1:0]     data_p1;
  logic              vld_p1;

  rr_pick #(
    .NUM_CH(NUM_CH),
    .CW    (CH_W)
  ) u_rr_pick (
    .req       (req_vld),
    .last_grant(last_grant),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    gnt_pix = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) gnt_pix = req_data[i*WI +: WI];
    end
  end

  assign xfer     = (state == ST_STREAM) && req_vld[grant];
  assign last_pix = (pix_cnt == CNT_W'(FRAME_SIZE - 1));

`ifdef FRAME_ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stall_trip;
  logic               err_flag;

  assign stall_trip = (state == ST_STREAM) && !req_vld[grant] &&
                      (stall_cnt == STALL_W'(STALL_MAX - 1));
  assign pad_emit   = (state == ST_PAD);
  assign frame_err  = (state == ST_DONE) && err_flag;

  // Consecutive-stall counter; any transfer or leaving STREAM restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (state != ST_STREAM || xfer) stall_cnt <= '0;
      else                            stall_cnt <= stall_cnt + 1'b1;
      if (state == ST_IDLE)  err_flag <= 1'b0;
      else if (stall_trip)   err_flag <= 1'b1;
    end
  end
`else
  assign pad_emit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_any) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (xfer && last_pix) state_nxt = ST_DONE;
`ifdef FRAME_ARB_WATCHDOG_EN
        else if (stall_trip)  state_nxt = ST_PAD;
`endif
      end
`ifdef FRAME_ARB_WATCHDOG_EN
      ST_PAD:    if (last_pix) state_nxt = ST_DONE;
`endif
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy = '0;
    if (state == ST_STREAM) req_rdy[grant] = 1'b1;
  end

  // Stage p1: accepted (or padded) pixel registered toward the image writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      pix_cnt    <= '0;
      data_p1    <= '0;
      vld_p1     <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= xfer || pad_emit;
      if (xfer)          data_p1 <= gnt_pix;
      else if (pad_emit) data_p1 <= '0;

      if (state == ST_IDLE && pick_any) begin
        grant   <= pick_idx;
        pix_cnt <= '0;
      end else if (xfer || pad_emit) begin
        pix_cnt <= pix_cnt + 1'b1;
      end

      if (state == ST_DONE) last_grant <= grant;
    end
  end

  assign out_data   = data_p1;
  assign out_vld    = vld_p1;
  assign out_ch     = grant;
  assign frame_done = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_fmap_frame_arbiter.sv
// Scoreboard bench for fmap_frame_arbiter (NUM_CH=4, WI=8, 4x2 frames, STALL_MAX=5).
// Watchdog scenario runs only when FRAME_ARB_WATCHDOG_EN is defined.
module tb_fmap_frame_arbiter;

  localparam int NCH = 4;
  localparam int WI  = 8;

  typedef struct {
    logic [7:0] data;
    int         delay;
    bit         last;
  } pix_t;

  typedef struct {
    logic [7:0] data;
    int         ch;
    bit         last;
    bit         err;
    int         acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_vld;
  logic [NCH*WI-1:0] req_data;
  logic [NCH-1:0]    req_rdy;
  logic [WI-1:0]     out_data;
  logic              out_vld;
  logic [1:0]        out_ch;
  logic              frame_done;
  logic              busy;
`ifdef FRAME_ARB_WATCHDOG_EN
  logic              frame_err;
`endif

  fmap_frame_arbiter #(
    .NUM_CH   (NCH),
    .WI       (WI),
    .WIDTH    (4),
    .HEIGHT   (2),
    .STALL_MAX(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_ch    (out_ch),
    .frame_done(frame_done),
`ifdef FRAME_ARB_WATCHDOG_EN
    .frame_err (frame_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  pix_t chq[NCH][$];
  exp_t sb[$];
  int   vld_t[$];
  int   done_ch[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input int ch, input logic [7:0] base, input int n,
                      input int first_delay, input int pause_idx, input int pause_len);
    pix_t p;
    for (int k = 0; k < n; k++) begin
      p.data  = base + 8'(k);
      p.delay = ((k == 0) ? first_delay : 0) + ((k == pause_idx) ? pause_len : 0);
      p.last  = ((k % 8) == 7);
      chq[ch].push_back(p);
    end
  endtask

  function automatic bit all_idle();
    bit e;
    e = (sb.size() == 0);
    for (int i = 0; i < NCH; i++) if (chq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string nm, input int maxc);
    int n;
    n = 0;
    while (!all_idle() && n < maxc) begin
      tick(1);
      n++;
    end
    if (!all_idle()) chk({nm, "_drain_timeout"}, n, -1);
  endtask

  task automatic chk_gap(input string nm, input int k, input int exp);
    if (k < vld_t.size()) chk(nm, vld_t[k] - vld_t[k-1], exp);
    else                  chk(nm, -1, exp);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) chq[i].delete();
    sb.delete();
    vld_t.delete();
    done_ch.delete();
    done_cnt = 0;
    err_cnt  = 0;
    tick(1);
    chk({nm, "_out_vld"},    out_vld, 0);
    chk({nm, "_out_data"},   out_data, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_busy"},       busy, 0);
    chk({nm, "_req_rdy"},    req_rdy, 0);
    chk({nm, "_out_ch"},     out_ch, 0);
`ifdef FRAME_ARB_WATCHDOG_EN
    chk({nm, "_frame_err"},  frame_err, 0);
`endif
    rst = 1'b0;
  endtask

  // Driver: presents each channel's queue head, records handshakes into the scoreboard.
  initial begin
    pix_t p;
    exp_t e;
    req_vld  = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        req_vld[i] = 1'b0;
        if (chq[i].size() != 0) begin
          if (chq[i][0].delay > 0) begin
            p = chq[i][0];
            p.delay--;
            chq[i][0] = p;
          end else begin
            req_vld[i] = 1'b1;
            req_data[i*WI +: WI] = chq[i][0].data;
          end
        end
      end
      #1;
      if (!rst) begin
        for (int i = 0; i < NCH; i++) begin
          if (req_vld[i] && req_rdy[i]) begin
            p = chq[i].pop_front();
            e.data = p.data;
            e.ch   = i;
            e.last = p.last;
            e.err  = 1'b0;
            e.acc  = cyc;
            sb.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every valid output pixel.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done) begin
          done_cnt++;
          done_ch.push_back(int'(out_ch));
          chk("done_with_vld", out_vld, 1);
        end
`ifdef FRAME_ARB_WATCHDOG_EN
        if (frame_err) err_cnt++;
`endif
        if (out_vld) begin
          vld_t.push_back(cyc);
          if (sb.size() == 0) begin
            chk("unexpected_out", int'(out_data), -1);
          end else begin
            e = sb.pop_front();
            chk("out_data",   out_data, e.data);
            chk("out_ch",     out_ch, e.ch);
            chk("frame_done", frame_done, e.last);
`ifdef FRAME_ARB_WATCHDOG_EN
            chk("frame_err",  frame_err, e.err);
`endif
            if (e.acc >= 0) chk("latency", cyc - e.acc, 1);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time exceeded at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int ord29[5];
    exp_t pe;
    ord29 = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    do_reset("rst0");

    // Single frame from ch2.
    load(2, 8'h10, 8, 0, -1, 0);
    drain("r28", 100);
    tick(2);
    chk("r28_done_cnt", done_cnt, 1);
    chk("r28_done_ch", (done_ch.size() > 0) ? done_ch[0] : -1, 2);
    chk("r28_busy", busy, 0);
    chk("r28_nout", vld_t.size(), 8);
    for (int k = 1; k < 8; k++) chk_gap("r28_gap", k, 1);

    // All channels continuously requesting.
    do_reset("rst29");
    load(0, 8'h00, 16, 0, -1, 0);
    load(1, 8'h40, 8, 0, -1, 0);
    load(2, 8'h80, 8, 0, -1, 0);
    load(3, 8'hC0, 8, 0, -1, 0);
    drain("r29", 300);
    tick(2);
    chk("r29_done_cnt", done_cnt, 5);
    for (int f = 0; f < 5; f++) chk("r29_order", (f < done_ch.size()) ? done_ch[f] : -1, ord29[f]);
    for (int k = 1; k < 40; k++) chk_gap("r29_gap", k, ((k % 8) == 0) ? 3 : 1);

    // ch1 stalls mid-frame; ch3 starts requesting during the ch1 frame.
    do_reset("rst30");
    load(1, 8'h20, 8, 0, 4, 3);
    load(3, 8'h30, 8, 4, -1, 0);
    drain("r30", 200);
    tick(2);
    chk("r30_done_cnt", done_cnt, 2);
    chk("r30_first_ch", (done_ch.size() > 0) ? done_ch[0] : -1, 1);
    chk("r30_second_ch", (done_ch.size() > 1) ? done_ch[1] : -1, 3);
    for (int k = 1; k < 16; k++) chk_gap("r30_gap", k, (k == 4) ? 4 : ((k == 8) ? 3 : 1));

    // Reset mid-frame, then a clean frame from ch0.
    do_reset("rst31a");
    load(0, 8'h50, 5, 0, -1, 0);
    drain("r31a", 100);
    tick(1);
    chk("r31_busy_mid", busy, 1);
    chk("r31_no_done_pre", done_cnt, 0);
    do_reset("rst31b");
    tick(3);
    chk("r31_no_done_post", done_cnt, 0);
    load(0, 8'h60, 8, 0, -1, 0);
    drain("r31b", 100);
    tick(2);
    chk("r31_done_cnt", done_cnt, 1);
    chk("r31_done_ch", (done_ch.size() > 0) ? done_ch[0] : -1, 0);
    chk("r31_nout", vld_t.size(), 8);

`ifdef FRAME_ARB_WATCHDOG_EN
    // ch0 stops after 3 pixels; watchdog pads the frame with zeros.
    do_reset("rst32");
    load(0, 8'h70, 3, 0, -1, 0);
    load(1, 8'h90, 8, 0, -1, 0);
    for (int n = 0; n < 50 && chq[0].size() != 0; n++) tick(1);
    chk("r32_ch0_sent", chq[0].size(), 0);
    for (int k = 0; k < 5; k++) begin
      pe.data = 8'h00;
      pe.ch   = 0;
      pe.last = (k == 4);
      pe.err  = (k == 4);
      pe.acc  = -1;
      sb.push_back(pe);
    end
    drain("r32", 200);
    tick(2);
    chk("r32_done_cnt", done_cnt, 2);
    chk("r32_err_cnt", err_cnt, 1);
    chk("r32_first_ch", (done_ch.size() > 0) ? done_ch[0] : -1, 0);
    chk("r32_next_ch", (done_ch.size() > 1) ? done_ch[1] : -1, 1);
    chk_gap("r32_pad_start", 3, 6);
    for (int k = 4; k < 8; k++) chk_gap("r32_pad_gap", k, 1);
`endif

    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_frame_arbiter.md
FMAP_FRAME_ARBITER -- requirements
Module: fmap_frame_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of feature-map producer channels (2..8).
REQ-002 SHALL have parameter WI, default 8, pixel width in bits.
REQ-003 SHALL have parameters WIDTH, default 128, and HEIGHT, default 128, frame dimensions in pixels; FRAME_SIZE = WIDTH*HEIGHT.
REQ-004 SHALL have parameter STALL_MAX, default 1024, stall-watchdog limit in cycles (used only under REQ-024).
REQ-005 SHALL provide: clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL provide: req_vld  input  NUM_CH  per-channel pixel valid.
REQ-008 SHALL provide: req_data  input  NUM_CH*WI  per-channel pixel, channel i at bits [i*WI +: WI].
REQ-009 SHALL provide: req_rdy  output  NUM_CH  per-channel accept; pixel transfers when vld && rdy.
REQ-010 SHALL provide: out_data  output  WI, out_vld  output  1  merged pixel stream to the image writer, no backpressure.
REQ-011 SHALL provide: out_ch  output  clog2(NUM_CH)  channel currently granted.
REQ-012 SHALL provide: frame_done  output  1  one-cycle pulse per completed frame; busy  output  1  high outside IDLE.

Function
REQ-013 SHALL implement states IDLE, STREAM, DONE.
REQ-014 IDLE: when any req_vld is high, SHALL register grant = first requesting channel searching from last_grant+1 modulo NUM_CH, clear the pixel counter, go to STREAM next cycle; no pixel is accepted in IDLE.
REQ-015 STREAM: req_rdy SHALL be high only for the granted channel, combinationally from state and grant; all other req_rdy low.
REQ-016 Each transfer SHALL register out_data = granted pixel and out_vld = 1 on the next cycle (latency 1); cycles without transfer give out_vld = 0.
REQ-017 Pixel counter SHALL be clog2(FRAME_SIZE) bits and increment per transfer; transfer at count FRAME_SIZE-1 moves to DONE, so req_rdy drops the following cycle.
REQ-018 DONE: SHALL last exactly one cycle, assert frame_done, set last_grant = grant, return to IDLE.
REQ-019 Grant SHALL be held for a whole frame; requests from other channels during STREAM are ignored until IDLE.
REQ-020 A granted channel dropping req_vld mid-frame SHALL only stall the counter; the grant is kept.
REQ-021 Inter-frame gap SHALL be exactly 2 cycles without transfer (DONE, IDLE) when requests are continuous.

Reset
REQ-022 rst SHALL force state IDLE, grant 0, last_grant NUM_CH-1 (channel 0 wins first), counter 0, out_vld 0, out_data 0, frame_done 0, req_rdy 0, busy 0, on the next clock edge.
REQ-023 rst mid-frame SHALL abandon the frame without frame_done; no partial-frame completion afterwards.

Configuration
REQ-024 With FRAME_ARB_WATCHDOG_EN defined: in STREAM, STALL_MAX consecutive cycles with granted req_vld low SHALL enter PAD state, deassert req_rdy, emit zero pixels with out_vld = 1 every cycle until the counter reaches FRAME_SIZE, then DONE with frame_done and output frame_err pulse (1 bit) in the same cycle; stall count clears on every transfer.
REQ-025 Without FRAME_ARB_WATCHDOG_EN: no PAD state, no frame_err port, stalls last indefinitely.

Structure
REQ-026 State encoding typedef and the state count constant SHALL live in shared package cnn_accel_pkg.
REQ-027 Round-robin select SHALL be sub-module rr_pick (inputs request vector and last_grant, output index and any-request flag, purely combinational).

Verification (bench uses NUM_CH=4, WI=8, WIDTH=4, HEIGHT=2, STALL_MAX=5)
REQ-028 After rst, ch2 sends 8 continuous pixels 0x10..0x17 -> out_ch=2, out_data 0x10..0x17 on 8 consecutive cycles one after acceptance, frame_done pulse once, busy low after.
REQ-029 All 4 channels request continuously -> frames granted in order 0,1,2,3,0; exactly 2 idle output cycles between frames.
REQ-030 ch1 granted, req_vld low for 3 cycles after pixel 4 -> out_vld low 3 cycles, remaining 4 pixels delivered, no frame_done early, ch3 requests during frame not granted until IDLE.
REQ-031 rst asserted after 5 pixels of ch0 -> no frame_done, outputs at reset values, next frame restarts at pixel count 0 with ch0.
REQ-032 With FRAME_ARB_WATCHDOG_EN, ch0 stops after 3 pixels -> after 5 stall cycles 5 zero pixels with out_vld=1, frame_done and frame_err pulse same cycle, next grant ch1.
